// File: rtl/ariane_stall_trace_encoder.sv
// Run-length encoder for issue-stage stall reasons. Consecutive identical codes
// collapse into {lost, code, run_len} records that are queued for host readout.
module ariane_stall_trace_encoder #(
    parameter int len_width_p  = 32,
    parameter int els_p        = 8,
    parameter int drop_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    stall_v_i,
    input  logic [5:0]              stall_reason_i,
    output logic                    v_o,
    output logic [len_width_p+6:0]  data_o,
    input  logic                    yumi_i,
    output logic [drop_width_p-1:0] dropped_o,
    output logic                    active_o
);

    localparam int rec_w_lp = len_width_p + 7;
    localparam int ptr_w_lp = $clog2(els_p);

    localparam logic [len_width_p-1:0]  len_one_lp  = len_width_p'(1'b1);
    localparam logic [ptr_w_lp-1:0]     ptr_one_lp  = ptr_w_lp'(1'b1);
    localparam logic [ptr_w_lp:0]       cnt_one_lp  = (ptr_w_lp + 1)'(1'b1);
    localparam logic [ptr_w_lp:0]       full_cnt_lp = (ptr_w_lp + 1)'(els_p);
    localparam logic [drop_width_p-1:0] drop_one_lp = drop_width_p'(1'b1);

    logic                    active_r;
    logic [5:0]              cur_code_r;
    logic [len_width_p-1:0]  run_len_r;
    logic                    lost_r;
    logic [drop_width_p-1:0] dropped_r;
    logic [ptr_w_lp-1:0]     wr_ptr_r;
    logic [ptr_w_lp-1:0]     rd_ptr_r;
    logic [ptr_w_lp:0]       count_r;
    logic                    v_r;
    logic [rec_w_lp-1:0]     data_r;
    logic [rec_w_lp-1:0]     mem_r [els_p];

    logic [5:0]              code_s;
    logic                    emit_s;
    logic                    full_s;
    logic                    push_ok_s;
    logic                    push_fail_s;
    logic                    pop_s;
    logic [rec_w_lp-1:0]     rec_s;
    logic [ptr_w_lp-1:0]     rd_ptr_n_s;
    logic [ptr_w_lp:0]       count_n_s;
    logic [rec_w_lp-1:0]     head_n_s;

    assign v_o       = v_r;
    assign data_o    = data_r;
    assign dropped_o = dropped_r;
    assign active_o  = active_r;

    // Run-boundary detection and FIFO next-state; the head is precomputed so data_o is a flop.
    always_comb begin
        code_s      = stall_v_i ? stall_reason_i : 6'h3F;
        emit_s      = active_r & (~enable_i | (code_s != cur_code_r) | (&run_len_r));
        full_s      = (count_r == full_cnt_lp);
        push_ok_s   = emit_s & ~full_s;
        push_fail_s = emit_s & full_s;
        pop_s       = yumi_i & v_r;
        rec_s       = {lost_r, cur_code_r, run_len_r};
        rd_ptr_n_s  = pop_s ? (rd_ptr_r + ptr_one_lp) : rd_ptr_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_n_s = count_r + cnt_one_lp;
            2'b01:   count_n_s = count_r - cnt_one_lp;
            default: count_n_s = count_r;
        endcase
        if (count_n_s == {(ptr_w_lp + 1){1'b0}}) begin
            head_n_s = {rec_w_lp{1'b0}};
        end else if (push_ok_s && (rd_ptr_n_s == wr_ptr_r)) begin
            head_n_s = rec_s;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // Record storage; contents are only meaningful below count_r, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !clear_i) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    // Run accumulation, loss tracking and FIFO pointers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            active_r   <= 1'b0;
            cur_code_r <= 6'h00;
            run_len_r  <= {len_width_p{1'b0}};
            lost_r     <= 1'b0;
            dropped_r  <= {drop_width_p{1'b0}};
            wr_ptr_r   <= {ptr_w_lp{1'b0}};
            rd_ptr_r   <= {ptr_w_lp{1'b0}};
            count_r    <= {(ptr_w_lp + 1){1'b0}};
            v_r        <= 1'b0;
            data_r     <= {rec_w_lp{1'b0}};
        end else if (clear_i) begin
            active_r   <= 1'b0;
            cur_code_r <= 6'h00;
            run_len_r  <= {len_width_p{1'b0}};
            lost_r     <= 1'b0;
            dropped_r  <= {drop_width_p{1'b0}};
            wr_ptr_r   <= {ptr_w_lp{1'b0}};
            rd_ptr_r   <= {ptr_w_lp{1'b0}};
            count_r    <= {(ptr_w_lp + 1){1'b0}};
            v_r        <= 1'b0;
            data_r     <= {rec_w_lp{1'b0}};
        end else begin
            if (enable_i) begin
                if (!active_r || emit_s) begin
                    cur_code_r <= code_s;
                    run_len_r  <= len_one_lp;
                    active_r   <= 1'b1;
                end else begin
                    run_len_r  <= run_len_r + len_one_lp;
                end
            end else if (active_r) begin
                active_r <= 1'b0;
            end else begin
                active_r <= 1'b0;
            end

            // A refused push marks the next accepted record as following a gap.
            if (push_ok_s) begin
                lost_r <= 1'b0;
            end else if (push_fail_s) begin
                lost_r <= 1'b1;
            end else begin
                lost_r <= lost_r;
            end

            if (push_fail_s && !(&dropped_r)) begin
                dropped_r <= dropped_r + drop_one_lp;
            end else begin
                dropped_r <= dropped_r;
            end

            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_one_lp;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r <= rd_ptr_n_s;
            count_r  <= count_n_s;
            v_r      <= (count_n_s != {(ptr_w_lp + 1){1'b0}});
            data_r   <= head_n_s;
        end
    end

endmodule

// File: tb/tb_ariane_stall_trace_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_ariane_stall_trace_encoder;

    localparam int LW  = 4;
    localparam int ELS = 4;
    localparam int DW  = 3;
    localparam int RW  = LW + 7;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          clear_i;
    logic          enable_i;
    logic          stall_v_i;
    logic [5:0]    stall_reason_i;
    logic          v_o;
    logic [RW-1:0] data_o;
    logic          yumi_i;
    logic [DW-1:0] dropped_o;
    logic          active_o;

    ariane_stall_trace_encoder #(
        .len_width_p (LW),
        .els_p       (ELS),
        .drop_width_p(DW)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .enable_i      (enable_i),
        .stall_v_i     (stall_v_i),
        .stall_reason_i(stall_reason_i),
        .v_o           (v_o),
        .data_o        (data_o),
        .yumi_i        (yumi_i),
        .dropped_o     (dropped_o),
        .active_o      (active_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued records, the open run, the loss flag and drop count.
    logic [RW-1:0] mq[$];
    bit            m_active;
    logic [5:0]    m_code;
    int            m_len;
    bit            m_lost;
    int            m_drop;
    logic [RW-1:0] got[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rec(bit l, int c, int n);
        logic [5:0]    cc;
        logic [LW-1:0] nn;
        cc = c[5:0];
        nn = n[LW-1:0];
        return {l, cc, nn};
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_code   = 6'd0;
        m_len    = 0;
        m_lost   = 0;
        m_drop   = 0;
        mq.delete();
    endtask

    task automatic model_edge();
        bit            full;
        bit            do_pop;
        bit            emit;
        logic [5:0]    c;
        logic [RW-1:0] r;
        if (clear_i) begin
            model_reset();
            return;
        end
        full   = (mq.size() == ELS);
        do_pop = yumi_i && (mq.size() > 0);
        c      = stall_v_i ? stall_reason_i : 6'h3F;
        emit   = 0;
        r      = '0;
        if (enable_i) begin
            if (!m_active) begin
                m_active = 1;
                m_code   = c;
                m_len    = 1;
            end else if (c == m_code && m_len < (1 << LW) - 1) begin
                m_len++;
            end else begin
                emit   = 1;
                r      = rec(m_lost, int'(m_code), m_len);
                m_code = c;
                m_len  = 1;
            end
        end else if (m_active) begin
            emit     = 1;
            r        = rec(m_lost, int'(m_code), m_len);
            m_active = 0;
        end
        if (do_pop) void'(mq.pop_front());
        if (emit) begin
            if (full) begin
                m_lost = 1;
                if (m_drop < (1 << DW) - 1) m_drop++;
            end else begin
                mq.push_back(r);
                m_lost = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("v_o", v_o, mq.size() != 0);
        if (mq.size() != 0) chk("data_o", data_o, mq[0]);
        chk("dropped_o", dropped_o, m_drop);
        chk("active_o", active_o, m_active);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic run(bit en, bit sv, int reason, int n);
        enable_i       = en;
        stall_v_i      = sv;
        stall_reason_i = reason[5:0];
        repeat (n) cycle();
    endtask

    task automatic drain();
        got.delete();
        enable_i = 1'b0;
        for (int i = 0; i < ELS + 1 && v_o; i++) begin
            got.push_back(data_o);
            yumi_i = 1'b1;
            cycle();
        end
        yumi_i = 1'b0;
        chk("drain_empty", v_o, 1'b0);
    endtask

    int reason_tbl[6] = '{0, 1, 26, 34, 35, 62};

    initial begin
        int hold;
        reset_i = 1'b1; clear_i = 1'b0; enable_i = 1'b0; stall_v_i = 1'b0;
        stall_reason_i = 6'd0; yumi_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_v", v_o, 1'b0);
        chk("rst_data", data_o, 11'd0);
        chk("rst_dropped", dropped_o, 3'd0);
        chk("rst_active", active_o, 1'b0);
        reset_i = 1'b0;
        cycle();

        // Basic run-length: 26 x4 then issue x6.
        run(1, 1, 26, 4);
        chk("basic_lat_pre", v_o, 1'b0);
        run(1, 0, 33, 1);
        chk("basic_lat_post", v_o, 1'b1);
        chk("basic_head", data_o, rec(0, 26, 4));
        run(1, 0, 12, 5);
        run(0, 0, 0, 1);
        chk("basic_active_off", active_o, 1'b0);
        drain();
        chk("basic_count", got.size(), 2);
        chk("basic_rec1", got[1], rec(0, 63, 6));

        // Saturation at 15 with the same code continuing.
        run(1, 1, 12, 20);
        run(0, 0, 0, 1);
        drain();
        chk("sat_count", got.size(), 2);
        chk("sat_rec0", got[0], rec(0, 12, 15));
        chk("sat_rec1", got[1], rec(0, 12, 5));

        // Overflow: alternate 1/2 with no pops; last two records lost.
        for (int i = 0; i < 6; i++) run(1, 1, (i % 2) + 1, 1);
        run(0, 0, 0, 1);
        chk("ovf_dropped", dropped_o, 3'd2);
        drain();
        chk("ovf_count", got.size(), 4);
        chk("ovf_rec0", got[0], rec(0, 1, 1));
        chk("ovf_rec3", got[3], rec(0, 2, 1));
        run(1, 1, 5, 3);
        run(0, 0, 0, 1);
        drain();
        chk("ovf_lost_rec", got[0], rec(1, 5, 3));

        // Async reset mid-run with one record queued.
        run(1, 1, 9, 1);
        run(1, 1, 7, 3);
        chk("ar_pre_v", v_o, 1'b1);
        chk("ar_pre_dropped", dropped_o, 3'd2);
        #2 reset_i = 1'b1;
        #1;
        chk("ar_v", v_o, 1'b0);
        chk("ar_active", active_o, 1'b0);
        chk("ar_dropped", dropped_o, 3'd0);
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        run(0, 0, 0, 1);

        // Full FIFO with a push and a pop in the same cycle.
        for (int i = 1; i <= 5; i++) run(1, 1, i, 1);
        yumi_i = 1'b1;
        run(1, 1, 6, 1);
        yumi_i = 1'b0;
        chk("fp_dropped", dropped_o, 3'd1);
        run(0, 0, 0, 1);
        drain();
        chk("fp_count", got.size(), 4);
        chk("fp_rec0", got[0], rec(0, 2, 1));
        chk("fp_rec3", got[3], rec(1, 6, 1));

        // Clear with a pop and a pending emit in the same cycle.
        run(1, 1, 9, 1);
        run(1, 1, 10, 2);
        clear_i = 1'b1;
        yumi_i  = 1'b1;
        run(1, 1, 11, 1);
        clear_i = 1'b0;
        yumi_i  = 1'b0;
        chk("clr_v", v_o, 1'b0);
        chk("clr_active", active_o, 1'b0);
        chk("clr_dropped", dropped_o, 3'd0);
        run(0, 0, 0, 1);
        chk("clr_no_rec", v_o, 1'b0);

        // Randomized traffic: long holds first, then dense changes with rare pops.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                hold           = (i < 1500) ? $urandom_range(1, 18) : $urandom_range(1, 3);
                enable_i       = ($urandom_range(0, 7) != 0);
                stall_v_i      = ($urandom_range(0, 3) != 0);
                stall_reason_i = 6'(reason_tbl[$urandom_range(0, 5)]);
            end
            hold--;
            yumi_i  = (mq.size() > 0) &&
                      ((i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0));
            clear_i = ($urandom_range(0, 299) == 0);
            cycle();
        end
        clear_i = 1'b0;
        yumi_i  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ariane_stall_trace_encoder.md
Name: ariane_stall_trace_encoder

Overview:
- Downstream consumer of the issue-stage stall classifier: takes the per-cycle stall-reason code and its valid qualifier, run-length encodes consecutive identical codes, and buffers the records for host readout.
- Gives a time-ordered stall trace that complements the aggregate per-reason counters.
- Sits between the issue profiler and the host-facing register/DMA drain in the cosim shell.

Parameters:
- len_width_p, 32, run-length field width; maximum run is 2^len_width_p-1 cycles.
- els_p, 8, record FIFO depth (power of two, >=2).
- drop_width_p, 32, width of the dropped-record counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- clear_i  in  1  synchronous clear; same effect as reset.
- enable_i  in  1  tracing enable; runs accumulate only while high.
- stall_v_i  in  1  issue stage did not issue this cycle.
- stall_reason_i  in  6  stall reason code, 0..34; sampled only when stall_v_i=1.
- v_o  out  1  record available at FIFO head.
- data_o  out  len_width_p+7  record {lost[1], code[6], run_len[len_width_p]}.
- yumi_i  in  1  consumer pops head; legal only when v_o=1.
- dropped_o  out  drop_width_p  saturating count of records lost to FIFO full.
- active_o  out  1  a run is currently being accumulated.

Behaviour:
- Reset: v_o=0, data_o=0, dropped_o=0, active_o=0; FIFO empty; cur_code_r=0, run_len_r=0, lost_r=0.
- clear_i=1: same state as reset, applied at the next clock edge. It overrides all other activity that cycle, including pops and pushes.
- Per-cycle code:
  - code_li = stall_v_i ? stall_reason_i : 6'h3F, where 3F means an instruction issued.
  - Codes 35..62 are passed through unchanged.
- While enable_i=1 and active_o=0: start a run. Set cur_code_r=code_li, run_len_r=1, active_o=1. Nothing is emitted.
- While enable_i=1 and active_o=1:
  - If code_li==cur_code_r and run_len_r is not at max: run_len_r+1.
  - Otherwise, emit {lost_r, cur_code_r, run_len_r} and start a new run with code_li and run_len_r=1.
  - A saturated run is emitted even when the code is unchanged; the next record continues with the same code.
- Run end on disable: enable_i=0 with active_o=1 emits the current run and clears active_o. The code sampled in that cycle is ignored.
- While enable_i=0 and active_o=0: no activity.
- Emit/push:
  - A push succeeds only if the FIFO is not full at the start of the cycle. A same-cycle pop does not make room.
  - Successful push: lost_r clears to 0.
  - Failed push: the record is discarded, lost_r is set to 1, and dropped_o increments, saturating at all-ones.
  - The first record accepted after any loss carries lost=1.
- Latency:
  - A pushed record appears at data_o with v_o=1 on the cycle after the push.
  - The FIFO is registered, with no fall-through.
  - The record emitted at edge N of a run change is visible from cycle N+1.
- Pop:
  - yumi_i=1 with v_o=1 removes the head at the clock edge. The next entry, if any, is presented the following cycle.
  - yumi_i with v_o=0 is illegal; the design ignores it, and verification flags it.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO: the push takes effect; the pop is illegal.
- Asynchronous reset asserted mid-run or with the FIFO non-empty: all state clears immediately. The in-flight run is discarded and is not counted as dropped.
- Width rules:
  - run_len_r is unsigned len_width_p bits.
  - Sum of run_len over all records plus the current run equals the number of enabled cycles, excluding cycles lost to drops.

Test Plan:
- Basic run-length: enable_i=1 for 10 cycles with stall reason 26 held for 4 cycles, then issue (stall_v_i=0) for 6 cycles, then enable_i=0 → records {0,26,4} and {0,3F,6} in order, each visible one cycle after its emitting edge; active_o=0 after the drop of enable_i.
- Saturation: len_width_p=4, reason 12 held for 20 enabled cycles, then disable → records {0,12,15} and {0,12,5}.
- Overflow: els_p=2, yumi_i=0, alternate codes 1/2 every cycle for 6 cycles, then disable → FIFO holds {0,1,1} and {0,2,1}, dropped_o=4. Pop both, re-enable, run code 5 for 3 cycles, disable → record {1,5,3}.
- Full plus pop: FIFO full and a push in the same cycle as yumi_i → push dropped, dropped_o+1, occupancy decreases by 1.
- Async reset mid-run: assert reset_i between edges during an 8-cycle run with 1 record queued → v_o=0, active_o=0 and dropped_o=0 immediately, without waiting for a clock edge.
- clear_i with yumi_i and a pending emit in the same cycle → state equals post-reset; dropped_o unchanged at 0 and no record appears.
